seq_game_engine: RTL and testbench

Parametrised round engine for the memory-sequence game. It grows a random digit sequence one symbol per round, plays it back on a flash output, and checks the player's entries against stored digits. It also keeps score and reports win, loss and timeout. It replaces the fixed-width RNG, timer and RAM cluster under the top-level game controller with one configurable block; login, display muxing and BCD conversion stay outside.

---
 rtl/seq_game_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_seq_game_engine.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_game_engine.sv
// Round engine for the memory-sequence game: LFSR symbol source, sequence store,
// timed flash playback, player-entry checking, timeout and saturating score.
module seq_game_engine #(
   parameter int          DIGIT_W        = 4,
   parameter int          MAX_LEN        = 16,
   parameter int          FLASH_CYCLES   = 50_000_000,
   parameter int          GAP_CYCLES     = 12_500_000,
   parameter int          TIMEOUT_CYCLES = 250_000_000,
   parameter int          SCORE_W        = 7,
   parameter logic [15:0] SEED           = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               digit_valid,
   input  logic [DIGIT_W-1:0] digit_in,
   output logic               flash_valid,
   output logic [DIGIT_W-1:0] flash_digit,
   output logic [2:0]         state,
   output logic [6:0]         seq_len,
   output logic [SCORE_W-1:0] score,
   output logic               correct_pulse,
   output logic               wrong_pulse,
   output logic               game_over,
   output logic               win
);

   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int CNT_W = 32;
   localparam int SUM_W = ((SCORE_W > 7) ? SCORE_W : 7) + 1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_GEN      = 3'd1,
      S_SHOW_ON  = 3'd2,
      S_SHOW_GAP = 3'd3,
      S_INPUT    = 3'd4,
      S_ROUND_OK = 3'd5,
      S_OVER     = 3'd6
   } state_t;

   state_t             r_state;
   logic [15:0]        r_lfsr;
   logic [DIGIT_W-1:0] r_mem [MAX_LEN];
   logic [IDX_W-1:0]   r_idx;
   logic [CNT_W-1:0]   r_cnt;
   logic [6:0]         r_len;
   logic [SCORE_W-1:0] r_score;
   logic               r_win;
   logic               r_correct;
   logic               r_wrong;
   logic               r_flash_valid;
   logic [DIGIT_W-1:0] r_flash_digit;
   logic               r_game_over;

   state_t             w_state_nx;
   logic [15:0]        w_lfsr_nx;
   logic [IDX_W-1:0]   w_idx_nx;
   logic [CNT_W-1:0]   w_cnt_nx;
   logic [6:0]         w_len_nx;
   logic [SCORE_W-1:0] w_score_nx;
   logic               w_win_nx;
   logic               w_correct_nx;
   logic               w_wrong_nx;
   logic               w_wr_en;
   logic [IDX_W-1:0]   w_last_idx;
   logic [DIGIT_W-1:0] w_sym;
   logic [DIGIT_W-1:0] w_rd_digit;
   logic [DIGIT_W-1:0] w_flash_digit_nx;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                  input logic [6:0] b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      if (s > SUM_W'(SCORE_MAX)) sat_add = SCORE_MAX;
      else                       sat_add = s[SCORE_W-1:0];
   endfunction

   // Galois right-shift form of x^16+x^14+x^13+x^11+1
   assign w_lfsr_nx  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   assign w_sym      = r_lfsr[DIGIT_W-1:0];
   assign w_last_idx = IDX_W'(r_len - 7'd1);
   assign w_rd_digit = r_mem[r_idx];

   always_comb begin
      w_state_nx       = r_state;
      w_idx_nx         = r_idx;
      w_cnt_nx         = r_cnt;
      w_len_nx         = r_len;
      w_score_nx       = r_score;
      w_win_nx         = r_win;
      w_correct_nx     = 1'b0;
      w_wrong_nx       = 1'b0;
      w_wr_en          = 1'b0;
      w_flash_digit_nx = '0;

      if (abort) begin
         w_state_nx = S_IDLE;
         w_idx_nx   = '0;
         w_len_nx   = '0;
         w_win_nx   = 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_OVER: begin
               if (start) begin
                  w_score_nx = '0;
                  w_len_nx   = 7'd1;
                  w_win_nx   = 1'b0;
                  w_state_nx = S_GEN;
               end
            end
            S_GEN: begin
               w_wr_en    = 1'b1;
               w_idx_nx   = '0;
               w_cnt_nx   = CNT_W'(FLASH_CYCLES - 1);
               w_state_nx = S_SHOW_ON;
            end
            S_SHOW_ON: begin
               if (r_cnt == '0) begin
                  w_cnt_nx   = CNT_W'(GAP_CYCLES - 1);
                  w_state_nx = S_SHOW_GAP;
               end else begin
                  w_cnt_nx = r_cnt - CNT_W'(1);
               end
            end
            S_SHOW_GAP: begin
               if (r_cnt != '0) begin
                  w_cnt_nx = r_cnt - CNT_W'(1);
               end else if (r_idx != w_last_idx) begin
                  w_idx_nx   = r_idx + IDX_W'(1);
                  w_cnt_nx   = CNT_W'(FLASH_CYCLES - 1);
                  w_state_nx = S_SHOW_ON;
               end else begin
                  w_idx_nx   = '0;
                  w_cnt_nx   = CNT_W'(TIMEOUT_CYCLES - 1);
                  w_state_nx = S_INPUT;
               end
            end
            S_INPUT: begin
               // an entry in the expiring cycle takes precedence over the timeout
               if (digit_valid) begin
                  if (digit_in == w_rd_digit) begin
                     w_correct_nx = 1'b1;
                     w_cnt_nx     = CNT_W'(TIMEOUT_CYCLES - 1);
                     if (r_idx == w_last_idx) w_state_nx = S_ROUND_OK;
                     else                     w_idx_nx   = r_idx + IDX_W'(1);
                  end else begin
                     w_wrong_nx = 1'b1;
                     w_state_nx = S_OVER;
                  end
               end else if (r_cnt == '0) begin
                  w_wrong_nx = 1'b1;
                  w_state_nx = S_OVER;
               end else begin
                  w_cnt_nx = r_cnt - CNT_W'(1);
               end
            end
            S_ROUND_OK: begin
               w_score_nx = sat_add(r_score, r_len);
               if (r_len == 7'(MAX_LEN)) begin
                  w_win_nx   = 1'b1;
                  w_state_nx = S_OVER;
               end else begin
                  w_len_nx   = r_len + 7'd1;
                  w_state_nx = S_GEN;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end

      // symbol being written this cycle is forwarded so playback starts without a bubble
      if (w_state_nx == S_SHOW_ON) begin
         if (w_wr_en && (w_idx_nx == w_last_idx)) w_flash_digit_nx = w_sym;
         else                                     w_flash_digit_nx = r_mem[w_idx_nx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_lfsr        <= SEED;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_len         <= '0;
         r_score       <= '0;
         r_win         <= 1'b0;
         r_correct     <= 1'b0;
         r_wrong       <= 1'b0;
         r_flash_valid <= 1'b0;
         r_flash_digit <= '0;
         r_game_over   <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_lfsr        <= w_lfsr_nx;
         r_idx         <= w_idx_nx;
         r_cnt         <= w_cnt_nx;
         r_len         <= w_len_nx;
         r_score       <= w_score_nx;
         r_win         <= w_win_nx;
         r_correct     <= w_correct_nx;
         r_wrong       <= w_wrong_nx;
         r_flash_valid <= (w_state_nx == S_SHOW_ON);
         r_flash_digit <= w_flash_digit_nx;
         r_game_over   <= (w_state_nx == S_OVER);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_last_idx] <= w_sym;
   end

   assign state         = r_state;
   assign seq_len       = r_len;
   assign score         = r_score;
   assign flash_valid   = r_flash_valid;
   assign flash_digit   = r_flash_digit;
   assign correct_pulse = r_correct;
   assign wrong_pulse   = r_wrong;
   assign game_over     = r_game_over;
   assign win           = r_win;

endmodule

// File: tb/tb_seq_game_engine.sv
// Directed bench for seq_game_engine: main instance (16 deep, short timings) and a
// three-round, 2-bit-score instance for win and score saturation.
module tb_seq_game_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, abort = 1'b0, dv = 1'b0;
   logic [3:0] din = 4'd0;
   logic       start2 = 1'b0, abort2 = 1'b0, dv2 = 1'b0;
   logic [3:0] din2 = 4'd0;

   logic       fv, cp, wp, go, wn;
   logic [3:0] fd;
   logic [2:0] st;
   logic [6:0] len;
   logic [6:0] sc;
   logic       fv2, cp2, wp2, go2, wn2;
   logic [3:0] fd2;
   logic [2:0] st2;
   logic [6:0] len2;
   logic [1:0] sc2;

   int         vecs = 0;
   int         errs = 0;
   logic [3:0] seq  [16];
   logic [3:0] wseq [3];
   logic [15:0] m_lfsr;

   seq_game_engine #(
      .DIGIT_W(4), .MAX_LEN(16), .FLASH_CYCLES(3), .GAP_CYCLES(2),
      .TIMEOUT_CYCLES(10), .SCORE_W(7), .SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .digit_valid(dv), .digit_in(din),
      .flash_valid(fv), .flash_digit(fd), .state(st), .seq_len(len),
      .score(sc), .correct_pulse(cp), .wrong_pulse(wp),
      .game_over(go), .win(wn)
   );

   seq_game_engine #(
      .DIGIT_W(4), .MAX_LEN(3), .FLASH_CYCLES(3), .GAP_CYCLES(2),
      .TIMEOUT_CYCLES(10), .SCORE_W(2), .SEED(16'hACE1)
   ) dut_w (
      .clk(clk), .rst(rst), .start(start2), .abort(abort2),
      .digit_valid(dv2), .digit_in(din2),
      .flash_valid(fv2), .flash_digit(fd2), .state(st2), .seq_len(len2),
      .score(sc2), .correct_pulse(cp2), .wrong_pulse(wp2),
      .game_over(go2), .win(wn2)
   );

   always #5 clk = ~clk;

   // reference LFSR: x^16+x^14+x^13+x^11+1, free-running like the DUT's
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 16'hACE1;
      else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   task automatic step;
      @(negedge clk);
   endtask

   task automatic pulse_start(input bit which);
      if (which) start2 = 1'b1; else start = 1'b1;
      step();
      start = 1'b0; start2 = 1'b0;
   endtask

   task automatic enter(input bit which, input logic [3:0] d);
      if (which) begin dv2 = 1'b1; din2 = d; end
      else       begin dv  = 1'b1; din  = d; end
      step();
      dv = 1'b0; dv2 = 1'b0;
   endtask

   task automatic wait_st(input bit which, input logic [2:0] s, input int budget,
                          output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         if ((which ? st2 : st) === s) ok = 1'b1;
         else step();
      end
   endtask

   // observe playback on the main instance from GEN until INPUT is reached
   task automatic watch_show(input int n, output int hi, output int tot, output int bad,
                             output logic [2:0] first);
      bit done;
      hi = 0; tot = 0; bad = 0; done = 1'b0; first = 3'd7;
      for (int i = 0; i < n * 5 + 20 && !done; i++) begin
         step();
         if (i == 0) first = st;
         if (st === 3'd4) done = 1'b1;
         else begin
            tot++;
            if (fv === 1'b1) begin
               if (hi / 3 >= 16 || fd !== seq[hi / 3]) bad++;
               hi++;
            end else if (fd !== 4'd0) bad++;
         end
      end
   endtask

   task automatic test_reset;
      #1 rst = 1'b0;
      step(); step();
      vecs++; if (st !== 3'd0) begin errs++; $display("FAIL reset_state: got %0d want 0", st); end
      vecs++; if ({fv, fd, cp, wp, go, wn} !== 10'd0) begin errs++; $display("FAIL reset_outs: got %b want 0", {fv, fd, cp, wp, go, wn}); end
      vecs++; if (len !== 7'd0 || sc !== 7'd0) begin errs++; $display("FAIL reset_len_score: len=%0d score=%0d want 0/0", len, sc); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_first_round;
      int hi, tot, bad; logic [2:0] first;
      pulse_start(0);
      vecs++; if (st !== 3'd1) begin errs++; $display("FAIL start_gen: state=%0d want 1", st); end
      seq[0] = m_lfsr[3:0];
      watch_show(1, hi, tot, bad, first);
      vecs++; if (first !== 3'd2) begin errs++; $display("FAIL gen_show_on: state=%0d want 2", first); end
      vecs++; if (hi !== 3) begin errs++; $display("FAIL flash_len: got %0d want 3", hi); end
      vecs++; if (tot !== 5) begin errs++; $display("FAIL show_len: got %0d want 5", tot); end
      vecs++; if (bad !== 0) begin errs++; $display("FAIL flash_digit: %0d bad cycles want 0", bad); end
      vecs++; if (st !== 3'd4) begin errs++; $display("FAIL input_entry: state=%0d want 4", st); end
   endtask

   task automatic test_echo;
      int hi, tot, bad, ncor; logic [2:0] first; bit ok;
      int exp_sc [3] = '{1, 3, 6};
      ncor = 0;
      for (int r = 1; r <= 3; r++) begin
         if (r > 1) begin
            wait_st(0, 3'd1, 5, ok);
            vecs++; if (!ok) begin errs++; $display("FAIL echo_gen r%0d: state=%0d want 1", r, st); end
            seq[r-1] = m_lfsr[3:0];
            watch_show(r, hi, tot, bad, first);
            vecs++; if (hi !== 3 * r || tot !== 5 * r || bad !== 0)
               begin errs++; $display("FAIL echo_show r%0d: hi=%0d tot=%0d bad=%0d want %0d/%0d/0", r, hi, tot, bad, 3 * r, 5 * r); end
         end
         for (int i = 0; i < r; i++) begin
            enter(0, seq[i]);
            if (cp === 1'b1) ncor++;
            vecs++; if (cp !== 1'b1 || wp !== 1'b0) begin errs++; $display("FAIL echo_pulse r%0d i%0d: cp=%b wp=%b want 1/0", r, i, cp, wp); end
         end
         vecs++; if (st !== 3'd5) begin errs++; $display("FAIL echo_round_ok r%0d: state=%0d want 5", r, st); end
         step();
         vecs++; if (sc !== 7'(exp_sc[r-1]) || st !== 3'd1) begin errs++; $display("FAIL echo_score r%0d: score=%0d state=%0d want %0d/1", r, sc, st, exp_sc[r-1]); end
      end
      vecs++; if (len !== 7'd4) begin errs++; $display("FAIL echo_len: got %0d want 4", len); end
      vecs++; if (ncor !== 6) begin errs++; $display("FAIL echo_correct_count: got %0d want 6", ncor); end
   endtask

   task automatic test_abort_show;
      step();
      vecs++; if (st !== 3'd2) begin errs++; $display("FAIL abort_pre: state=%0d want 2", st); end
      abort = 1'b1;
      step();
      abort = 1'b0;
      vecs++; if (st !== 3'd0 || fv !== 1'b0) begin errs++; $display("FAIL abort_idle: state=%0d fv=%b want 0/0", st, fv); end
      vecs++; if (sc !== 7'd6 || len !== 7'd0) begin errs++; $display("FAIL abort_hold: score=%0d len=%0d want 6/0", sc, len); end
   endtask

   task automatic test_gap_and_wrong;
      int hi, tot, bad; logic [2:0] first; bit ok;
      pulse_start(0);
      vecs++; if (st !== 3'd1 || sc !== 7'd0 || len !== 7'd1) begin errs++; $display("FAIL restart: state=%0d score=%0d len=%0d want 1/0/1", st, sc, len); end
      seq[0] = m_lfsr[3:0];
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      vecs++; if (st !== 3'd2 || len !== 7'd1) begin errs++; $display("FAIL start_ignored: state=%0d len=%0d want 2/1", st, len); end
      wait_st(0, 3'd3, 10, ok);
      vecs++; if (!ok) begin errs++; $display("FAIL gap_reach: state=%0d want 3", st); end
      enter(0, seq[0]);
      vecs++; if (cp !== 1'b0 || wp !== 1'b0 || st !== 3'd3) begin errs++; $display("FAIL gap_ignore1: cp=%b wp=%b state=%0d want 0/0/3", cp, wp, st); end
      enter(0, seq[0] ^ 4'd1);
      vecs++; if (cp !== 1'b0 || wp !== 1'b0 || st !== 3'd4) begin errs++; $display("FAIL gap_ignore2: cp=%b wp=%b state=%0d want 0/0/4", cp, wp, st); end
      enter(0, seq[0]);
      step();
      vecs++; if (st !== 3'd1 || sc !== 7'd1) begin errs++; $display("FAIL wrong_r1: state=%0d score=%0d want 1/1", st, sc); end
      seq[1] = m_lfsr[3:0];
      watch_show(2, hi, tot, bad, first);
      enter(0, seq[0] ^ 4'd1);
      vecs++; if (wp !== 1'b1 || cp !== 1'b0 || st !== 3'd6) begin errs++; $display("FAIL wrong_entry: wp=%b cp=%b state=%0d want 1/0/6", wp, cp, st); end
      vecs++; if (go !== 1'b1 || wn !== 1'b0 || sc !== 7'd1) begin errs++; $display("FAIL wrong_over: go=%b win=%b score=%0d want 1/0/1", go, wn, sc); end
      step();
      vecs++; if (wp !== 1'b0 || st !== 3'd6) begin errs++; $display("FAIL wrong_pulse_len: wp=%b state=%0d want 0/6", wp, st); end
      pulse_start(0);
      vecs++; if (st !== 3'd1 || len !== 7'd1 || sc !== 7'd0 || go !== 1'b0) begin errs++; $display("FAIL over_restart: state=%0d len=%0d score=%0d go=%b want 1/1/0/0", st, len, sc, go); end
   endtask

   task automatic test_timeout;
      int hi, tot, bad, t; logic [2:0] first;
      seq[0] = m_lfsr[3:0];
      watch_show(1, hi, tot, bad, first);
      t = 0;
      for (int i = 0; i < 30 && wp !== 1'b1; i++) begin step(); t++; end
      vecs++; if (t !== 10 || st !== 3'd6) begin errs++; $display("FAIL timeout_plain: at %0d state=%0d want 10/6", t, st); end
      pulse_start(0);
      seq[0] = m_lfsr[3:0];
      watch_show(1, hi, tot, bad, first);
      enter(0, seq[0]);
      step();
      seq[1] = m_lfsr[3:0];
      watch_show(2, hi, tot, bad, first);
      repeat (4) step();
      enter(0, seq[0]);
      vecs++; if (cp !== 1'b1) begin errs++; $display("FAIL timeout_entry5: cp=%b want 1", cp); end
      t = 5;
      for (int i = 0; i < 30 && wp !== 1'b1; i++) begin step(); t++; end
      vecs++; if (t !== 15 || st !== 3'd6) begin errs++; $display("FAIL timeout_reload: at %0d state=%0d want 15/6", t, st); end
   endtask

   task automatic test_win;
      bit ok;
      logic [1:0] exp_sc [3] = '{2'd1, 2'd3, 2'd3};
      pulse_start(1);
      for (int r = 1; r <= 3; r++) begin
         wait_st(1, 3'd1, 5, ok);
         wseq[r-1] = m_lfsr[3:0];
         wait_st(1, 3'd4, r * 5 + 10, ok);
         vecs++; if (!ok) begin errs++; $display("FAIL win_input r%0d: state=%0d want 4", r, st2); end
         for (int i = 0; i < r; i++) enter(1, wseq[i]);
         vecs++; if (st2 !== 3'd5 || cp2 !== 1'b1) begin errs++; $display("FAIL win_round r%0d: state=%0d cp=%b want 5/1", r, st2, cp2); end
         step();
         vecs++; if (sc2 !== exp_sc[r-1]) begin errs++; $display("FAIL win_score r%0d: got %0d want %0d", r, sc2, exp_sc[r-1]); end
      end
      vecs++; if (st2 !== 3'd6 || wn2 !== 1'b1 || go2 !== 1'b1) begin errs++; $display("FAIL win_over: state=%0d win=%b go=%b want 6/1/1", st2, wn2, go2); end
      vecs++; if (len2 !== 7'd3) begin errs++; $display("FAIL win_len: got %0d want 3", len2); end
   endtask

   task automatic test_reset_mid;
      int hi, tot, bad; logic [2:0] first;
      pulse_start(0);
      seq[0] = m_lfsr[3:0];
      watch_show(1, hi, tot, bad, first);
      enter(0, seq[0]);
      step();
      seq[1] = m_lfsr[3:0];
      watch_show(2, hi, tot, bad, first);
      vecs++; if (st !== 3'd4 || sc !== 7'd1) begin errs++; $display("FAIL rst_pre: state=%0d score=%0d want 4/1", st, sc); end
      #2 rst = 1'b0;
      #1;
      vecs++; if (st !== 3'd0 || sc !== 7'd0 || len !== 7'd0) begin errs++; $display("FAIL rst_async: state=%0d score=%0d len=%0d want 0/0/0", st, sc, len); end
      vecs++; if ({fv, fd, cp, wp, go, wn} !== 10'd0 || wn2 !== 1'b0 || sc2 !== 2'd0) begin errs++; $display("FAIL rst_async_outs: %b win2=%b score2=%0d want 0", {fv, fd, cp, wp, go, wn}, wn2, sc2); end
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_first_round();
      test_echo();
      test_abort_show();
      test_gap_and_wrong();
      test_timeout();
      test_win();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
